// File: rtl/rvx_dbus_interconnect_pkg.sv
// Shared definitions for the data-bus interconnect: FSM state encoding,
// the default device map (RAM, UART, TIMER, GPIO) and width helpers.
package rvx_dbus_interconnect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_DEV = 2'b01,
    ST_WAIT_ERR = 2'b10
  } bus_state_t;

  localparam logic [31:0] RAM_BASE   = 32'h8000_0000;
  localparam logic [31:0] RAM_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] UART_BASE  = 32'h9000_0000;
  localparam logic [31:0] UART_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] TIMER_BASE = 32'h9000_1000;
  localparam logic [31:0] TIMER_MASK = 32'hFFFF_F000;
  localparam logic [31:0] GPIO_BASE  = 32'h9000_2000;
  localparam logic [31:0] GPIO_MASK  = 32'hFFFF_F000;

  // Slot 0 sits in the least significant word.
  localparam logic [127:0] DEFAULT_BASES = {GPIO_BASE, TIMER_BASE, UART_BASE, RAM_BASE};
  localparam logic [127:0] DEFAULT_MASKS = {GPIO_MASK, TIMER_MASK, UART_MASK, RAM_MASK};

  // Width of a device index; never narrower than one bit.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the wait counter; a disabled timeout still needs one bit.
  function automatic int count_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/rvx_dbus_interconnect_decoder.sv
// Combinational address decoder: compares the address against every
// base/mask pair and resolves overlaps in favour of the lowest index.
module rvx_bus_address_decoder
  import rvx_dbus_interconnect_pkg::*;
#(
  parameter int                        NUM_DEVICES           = 4,
  parameter logic [32*NUM_DEVICES-1:0] DEVICE_BASE_ADDRESSES = DEFAULT_BASES,
  parameter logic [32*NUM_DEVICES-1:0] DEVICE_ADDRESS_MASKS  = DEFAULT_MASKS,
  localparam int                       IDX_W                 = index_width(NUM_DEVICES)
) (
  input  logic [31:0]            address,
  output logic [NUM_DEVICES-1:0] hit,
  output logic [NUM_DEVICES-1:0] select,
  output logic [IDX_W-1:0]       index,
  output logic                   unmapped
);

  // Raw hits per device, then a priority scan so the lowest hit wins.
  always_comb begin
    hit      = '0;
    select   = '0;
    index    = '0;
    unmapped = 1'b1;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      hit[i] = ((address & DEVICE_ADDRESS_MASKS[32*i +: 32]) == DEVICE_BASE_ADDRESSES[32*i +: 32]);
    end
    for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        select    = '0;
        select[i] = 1'b1;
        index     = IDX_W'(i);
        unmapped  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rvx_dbus_interconnect.sv
// Data-bus interconnect: routes each core load/store to one device with zero
// added latency, returns the device response, and synthesises error or
// timeout completions so the core can never stall forever.
module rvx_dbus_interconnect
  import rvx_dbus_interconnect_pkg::*;
#(
  parameter int                        NUM_DEVICES           = 4,
  parameter logic [32*NUM_DEVICES-1:0] DEVICE_BASE_ADDRESSES = DEFAULT_BASES,
  parameter logic [32*NUM_DEVICES-1:0] DEVICE_ADDRESS_MASKS  = DEFAULT_MASKS,
  parameter int                        TIMEOUT_CYCLES        = 1024
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [31:0]               m_address,
  input  logic                      m_rrequest,
  input  logic                      m_wrequest,
  input  logic [31:0]               m_wdata,
  input  logic [3:0]                m_wstrobe,
  output logic [31:0]               m_rdata,
  output logic                      m_rresponse,
  output logic                      m_wresponse,
  output logic [31:0]               dev_address,
  output logic [31:0]               dev_wdata,
  output logic [3:0]                dev_wstrobe,
  output logic [NUM_DEVICES-1:0]    dev_rrequest,
  output logic [NUM_DEVICES-1:0]    dev_wrequest,
  input  logic [32*NUM_DEVICES-1:0] dev_rdata,
  input  logic [NUM_DEVICES-1:0]    dev_rresponse,
  input  logic [NUM_DEVICES-1:0]    dev_wresponse,
  output logic                      bus_error,
  output logic                      bus_timeout
);

  localparam int              IDX_W    = index_width(NUM_DEVICES);
  localparam int              CNT_W    = count_width(TIMEOUT_CYCLES);
  localparam bit              TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  bus_state_t             state;
  bus_state_t             state_next;
  logic [IDX_W-1:0]       sel_idx;
  logic                   is_write;
  logic [CNT_W-1:0]       wait_count;

  logic [NUM_DEVICES-1:0] dec_hit;
  logic [NUM_DEVICES-1:0] dec_select;
  logic [IDX_W-1:0]       dec_index;
  logic                   dec_unmapped;

  logic                   sel_rresp;
  logic                   sel_wresp;
  logic [31:0]            sel_rdata;

  logic                   in_idle;
  logic                   in_wait_dev;
  logic                   in_wait_err;
  logic                   req_any;
  logic                   mapped;
  logic                   resp_hit;
  logic                   tmo_hit;
  logic                   completing;
  logic                   accept;

  rvx_bus_address_decoder #(
    .NUM_DEVICES           (NUM_DEVICES),
    .DEVICE_BASE_ADDRESSES (DEVICE_BASE_ADDRESSES),
    .DEVICE_ADDRESS_MASKS  (DEVICE_ADDRESS_MASKS)
  ) u_decoder (
    .address  (m_address),
    .hit      (dec_hit),
    .select   (dec_select),
    .index    (dec_index),
    .unmapped (dec_unmapped)
  );

  // Address and write payload go to every device unchanged.
  assign dev_address = m_address;
  assign dev_wdata   = m_wdata;
  assign dev_wstrobe = m_wstrobe;

  assign in_idle     = (state == ST_IDLE);
  assign in_wait_dev = (state == ST_WAIT_DEV);
  assign in_wait_err = (state == ST_WAIT_ERR);
  assign req_any     = m_rrequest | m_wrequest;
  assign mapped      = |dec_hit;

  // Only the latched device's response of the latched kind can complete.
  assign resp_hit    = in_wait_dev & (is_write ? sel_wresp : sel_rresp);
  assign tmo_hit     = TMO_EN & in_wait_dev & ~resp_hit & (wait_count == TMO_LAST);
  assign completing  = resp_hit | tmo_hit | in_wait_err;
  // A request is taken when idle or in the same cycle the previous one ends.
  assign accept      = req_any & (in_idle | completing);

  // Pick the latched device's response bits and read data.
  always_comb begin
    sel_rresp = 1'b0;
    sel_wresp = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (IDX_W'(i) == sel_idx) begin
        sel_rresp = dev_rresponse[i];
        sel_wresp = dev_wresponse[i];
        sel_rdata = dev_rdata[32*i +: 32];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: a new accept decides the wait kind, otherwise a completion returns to idle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_WAIT_DEV, ST_WAIT_ERR: begin
        if (accept) begin
          state_next = dec_unmapped ? ST_WAIT_ERR : ST_WAIT_DEV;
        end else if (completing) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Transaction context captured on accept.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sel_idx  <= '0;
      is_write <= 1'b0;
    end else if (accept) begin
      sel_idx  <= dec_index;
      is_write <= m_wrequest;
    end
  end

  // Wait counter: restarts on accept, counts device-wait cycles, saturates.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wait_count <= '0;
    end else if (accept) begin
      wait_count <= '0;
    end else if (in_wait_dev && (wait_count != '1)) begin
      wait_count <= wait_count + 1'b1;
    end
  end

  // FSM outputs: request fan-out, response mux and error/timeout pulses, all held low in reset.
  always_comb begin
    dev_rrequest = '0;
    dev_wrequest = '0;
    m_rresponse  = 1'b0;
    m_wresponse  = 1'b0;
    m_rdata      = '0;
    bus_error    = 1'b0;
    bus_timeout  = 1'b0;
    if (reset_n) begin
      if (accept) begin
        if (mapped) begin
          if (m_wrequest) begin
            dev_wrequest = dec_select;
          end else begin
            dev_rrequest = dec_select;
          end
        end
      end else if (in_wait_dev) begin
        for (int i = 0; i < NUM_DEVICES; i++) begin
          if (IDX_W'(i) == sel_idx) begin
            dev_wrequest[i] = is_write;
            dev_rrequest[i] = ~is_write;
          end
        end
      end
      if (in_wait_dev && (resp_hit || tmo_hit)) begin
        m_wresponse = is_write;
        m_rresponse = ~is_write;
        bus_timeout = tmo_hit;
        if (resp_hit && !is_write) begin
          m_rdata = sel_rdata;
        end
      end
      if (in_wait_err) begin
        m_wresponse = is_write;
        m_rresponse = ~is_write;
        bus_error   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rvx_dbus_interconnect.sv
// Directed bench for the data-bus interconnect with a transaction-level
// reference model compared every cycle, plus literal spot checks.
module tb_rvx_dbus_interconnect;

  localparam int TMO = 8;
  // Device 3 deliberately overlaps devices 1 and 2 so priority matters.
  localparam logic [127:0] MAP_BASES = {32'h9000_0000, 32'h9000_1000, 32'h9000_0000, 32'h8000_0000};
  localparam logic [127:0] MAP_MASKS = {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000};

  logic         clock = 1'b0;
  logic         reset_n;
  logic [31:0]  m_address;
  logic         m_rrequest;
  logic         m_wrequest;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wstrobe;
  logic [31:0]  m_rdata;
  logic         m_rresponse;
  logic         m_wresponse;
  logic [31:0]  dev_address;
  logic [31:0]  dev_wdata;
  logic [3:0]   dev_wstrobe;
  logic [3:0]   dev_rrequest;
  logic [3:0]   dev_wrequest;
  logic [127:0] dev_rdata;
  logic [3:0]   dev_rresponse;
  logic [3:0]   dev_wresponse;
  logic         bus_error;
  logic         bus_timeout;

  int checks   = 0;
  int failures = 0;

  rvx_dbus_interconnect #(
    .NUM_DEVICES           (4),
    .DEVICE_BASE_ADDRESSES (MAP_BASES),
    .DEVICE_ADDRESS_MASKS  (MAP_MASKS),
    .TIMEOUT_CYCLES        (TMO)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .m_address     (m_address),
    .m_rrequest    (m_rrequest),
    .m_wrequest    (m_wrequest),
    .m_wdata       (m_wdata),
    .m_wstrobe     (m_wstrobe),
    .m_rdata       (m_rdata),
    .m_rresponse   (m_rresponse),
    .m_wresponse   (m_wresponse),
    .dev_address   (dev_address),
    .dev_wdata     (dev_wdata),
    .dev_wstrobe   (dev_wstrobe),
    .dev_rrequest  (dev_rrequest),
    .dev_wrequest  (dev_wrequest),
    .dev_rdata     (dev_rdata),
    .dev_rresponse (dev_rresponse),
    .dev_wresponse (dev_wresponse),
    .bus_error     (bus_error),
    .bus_timeout   (bus_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // First matching device in index order, -1 when nothing matches.
  function automatic int lookup(input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      if ((a & MAP_MASKS[32*i +: 32]) == MAP_BASES[32*i +: 32]) return i;
    end
    return -1;
  endfunction

  // Reference model: one outstanding transaction described by target, kind and age.
  bit mdl_busy = 1'b0;
  int mdl_dev  = 0;
  bit mdl_wr   = 1'b0;
  int mdl_age  = 0;

  initial begin
    forever begin
      logic [3:0]  e_rreq, e_wreq;
      logic        e_rresp, e_wresp, e_err, e_tmo;
      logic [31:0] e_rdata;
      bit n_busy, n_wr, done, acc;
      int n_dev, n_age, d;
      @(negedge clock);
      e_rreq = '0; e_wreq = '0; e_rresp = 1'b0; e_wresp = 1'b0;
      e_err = 1'b0; e_tmo = 1'b0; e_rdata = '0;
      n_busy = mdl_busy; n_dev = mdl_dev; n_wr = mdl_wr; n_age = mdl_age;
      if (!reset_n) begin
        n_busy = 1'b0;
      end else begin
        d    = lookup(m_address);
        done = 1'b0;
        if (mdl_busy) begin
          if (mdl_dev < 0) begin
            done  = 1'b1;
            e_err = 1'b1;
          end else if (mdl_wr ? dev_wresponse[mdl_dev] : dev_rresponse[mdl_dev]) begin
            done = 1'b1;
            if (!mdl_wr) e_rdata = dev_rdata[32*mdl_dev +: 32];
          end else if (mdl_age == TMO) begin
            done  = 1'b1;
            e_tmo = 1'b1;
          end
          if (done) begin
            e_rresp = !mdl_wr;
            e_wresp = mdl_wr;
          end
        end
        acc = (m_rrequest || m_wrequest) && (!mdl_busy || done);
        if (acc) begin
          if (d >= 0) begin
            if (m_wrequest) e_wreq[d] = 1'b1;
            else            e_rreq[d] = 1'b1;
          end
          n_busy = 1'b1; n_dev = d; n_wr = m_wrequest; n_age = 1;
        end else begin
          if (mdl_busy && mdl_dev >= 0) begin
            if (mdl_wr) e_wreq[mdl_dev] = 1'b1;
            else        e_rreq[mdl_dev] = 1'b1;
          end
          if (done) n_busy = 1'b0;
          else if (mdl_busy) n_age = mdl_age + 1;
        end
      end
      chk("mdl_dev_rrequest", 32'(dev_rrequest), 32'(e_rreq));
      chk("mdl_dev_wrequest", 32'(dev_wrequest), 32'(e_wreq));
      chk("mdl_m_rresponse",  32'(m_rresponse),  32'(e_rresp));
      chk("mdl_m_wresponse",  32'(m_wresponse),  32'(e_wresp));
      chk("mdl_m_rdata",      m_rdata,           e_rdata);
      chk("mdl_bus_error",    32'(bus_error),    32'(e_err));
      chk("mdl_bus_timeout",  32'(bus_timeout),  32'(e_tmo));
      chk("mdl_dev_address",  dev_address,       m_address);
      chk("mdl_dev_wdata",    dev_wdata,         m_wdata);
      chk("mdl_dev_wstrobe",  32'(dev_wstrobe),  32'(m_wstrobe));
      @(posedge clock);
      mdl_busy = n_busy; mdl_dev = n_dev; mdl_wr = n_wr; mdl_age = n_age;
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  task automatic quiet();
    m_rrequest = 1'b0; m_wrequest = 1'b0;
    dev_rresponse = '0; dev_wresponse = '0; dev_rdata = '0;
  endtask

  initial begin
    reset_n = 1'b0; m_address = '0; m_wdata = '0; m_wstrobe = '0;
    quiet();
    repeat (3) tick();
    settle();
    chk("reset_outputs", {dev_rrequest, dev_wrequest, 22'b0, m_rresponse, m_wresponse}, 32'h0);

    // Read to dev0, answered two cycles later.
    tick(); reset_n = 1'b1; m_address = 32'h8000_0010; m_rrequest = 1'b1;
    settle(); chk("t1_rreq", 32'(dev_rrequest), 32'h1); chk("t1_no_resp", 32'(m_rresponse), 32'h0);
    tick();
    tick(); m_rrequest = 1'b0; dev_rresponse = 4'b0001; dev_rdata[31:0] = 32'hCAFE_F00D;
    settle(); chk("t1_resp", 32'(m_rresponse), 32'h1); chk("t1_rdata", m_rdata, 32'hCAFE_F00D);
    tick(); quiet();
    settle(); chk("t1_resp_gone", 32'(m_rresponse), 32'h0);

    // Write to dev1 (overlaps dev3), then a read to dev2 in the completion cycle.
    tick(); m_address = 32'h9000_0004; m_wrequest = 1'b1; m_wdata = 32'h1122_3344; m_wstrobe = 4'hF;
    settle(); chk("t2_wreq", 32'(dev_wrequest), 32'h2);
    tick(); dev_wresponse = 4'b0010; m_wrequest = 1'b0; m_rrequest = 1'b1; m_address = 32'h9000_1008;
    settle(); chk("t2_wresp", 32'(m_wresponse), 32'h1); chk("t2_rreq_b2b", 32'(dev_rrequest), 32'h4);
    tick(); dev_wresponse = 4'b0100; dev_rresponse = 4'b0010;
    settle(); chk("t2_stray_ignored", 32'(m_rresponse), 32'h0);
    tick(); dev_wresponse = '0; dev_rresponse = 4'b0100; dev_rdata[95:64] = 32'hA5A5_0002; m_rrequest = 1'b0;
    settle(); chk("t2_rresp", 32'(m_rresponse), 32'h1); chk("t2_rdata", m_rdata, 32'hA5A5_0002);
    tick(); quiet();

    // Unmapped read.
    tick(); m_address = 32'h4000_0000; m_rrequest = 1'b1;
    settle(); chk("t3_no_req", 32'(dev_rrequest | dev_wrequest), 32'h0); chk("t3_no_err_yet", 32'(bus_error), 32'h0);
    tick(); m_rrequest = 1'b0;
    settle(); chk("t3_rresp", 32'(m_rresponse), 32'h1); chk("t3_err", 32'(bus_error), 32'h1);
    chk("t3_rdata", m_rdata, 32'h0);
    tick();
    settle(); chk("t3_err_pulse", 32'(bus_error), 32'h0);

    // Unmapped write just past the RAM window, then a dev0 read out of the error completion.
    tick(); m_address = 32'h8001_0000; m_wrequest = 1'b1; m_wdata = 32'hDEAD_BEEF; m_wstrobe = 4'h3;
    tick(); m_wrequest = 1'b0; m_rrequest = 1'b1; m_address = 32'h8000_0080;
    settle(); chk("t4_werr", {30'b0, m_wresponse, bus_error}, 32'h3); chk("t4_rreq", 32'(dev_rrequest), 32'h1);
    tick(); m_rrequest = 1'b0; dev_rresponse = 4'b0001; dev_rdata[31:0] = 32'h1234_5678;
    settle(); chk("t4_rdata", m_rdata, 32'h1234_5678);
    tick(); quiet();

    // Write to dev3 that never answers: timeout at the 8th wait cycle.
    tick(); m_address = 32'h9000_3000; m_wrequest = 1'b1; m_wdata = 32'h0BAD_CAFE; m_wstrobe = 4'hF;
    settle(); chk("t5_wreq", 32'(dev_wrequest), 32'h8);
    for (int i = 1; i <= TMO; i++) begin
      tick();
      if (i == TMO) m_wrequest = 1'b0;
      settle();
      if (i < TMO) chk("t5_waiting", 32'(m_wresponse | bus_timeout), 32'h0);
    end
    chk("t5_wresp", 32'(m_wresponse), 32'h1); chk("t5_timeout", 32'(bus_timeout), 32'h1);
    chk("t5_req_held", 32'(dev_wrequest), 32'h8);
    tick();
    settle(); chk("t5_req_dropped", 32'(dev_wrequest), 32'h0);
    tick(); tick(); dev_wresponse = 4'b1000;
    settle(); chk("t5_late_ignored", 32'(m_wresponse), 32'h0);
    tick(); quiet();

    // Read and write together: the write wins.
    tick(); m_address = 32'h8000_0020; m_rrequest = 1'b1; m_wrequest = 1'b1; m_wdata = 32'h5555_AAAA;
    settle(); chk("t6_wreq_only", {dev_rrequest, dev_wrequest}, 32'h01);
    tick(); dev_rresponse = 4'b0001;
    settle(); chk("t6_read_ignored", 32'(m_rresponse | m_wresponse), 32'h0);
    tick(); dev_rresponse = '0; dev_wresponse = 4'b0001; m_rrequest = 1'b0; m_wrequest = 1'b0;
    settle(); chk("t6_wresp", {30'b0, m_rresponse, m_wresponse}, 32'h1);
    tick(); quiet();

    // Reset in the middle of a dev0 read.
    tick(); m_address = 32'h8000_0040; m_rrequest = 1'b1;
    tick(); reset_n = 1'b0;
    tick(); reset_n = 1'b1; m_rrequest = 1'b0;
    settle(); chk("t7_outputs_zero", {dev_rrequest, dev_wrequest, 20'b0, m_rresponse, m_wresponse, bus_error, bus_timeout}, 32'h0);
    tick(); dev_rresponse = 4'b0001; dev_rdata[31:0] = 32'h7777_7777;
    settle(); chk("t7_not_forwarded", 32'(m_rresponse), 32'h0); chk("t7_rdata_zero", m_rdata, 32'h0);
    tick(); quiet();
    tick();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
